data_memory_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/data_memory_ctrl_if.sv | 30 +++
 rtl/dmem_lane_align.sv | 35 +++
 rtl/data_memory_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory: access-size encodings,
// controller state type and the byte-enable / alignment helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Byte-enable for an access of the given size starting at lane offset off.
  function automatic logic [7:0] byte_enable(input logic [1:0] size,
                                             input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // Misaligned access, or a doubleword on a 32-bit memory.
  function automatic logic access_fault(input logic [1:0] size,
                                        input logic [2:0] off,
                                        input logic       is64);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off[1:0] != 2'b00;
      default: return !is64 || (off != 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the load/store stage (master) and the data
// memory (slave).
interface data_memory_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_fault;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: shifts store data up to the lane offset and
// extracts / extends load data down from it.
module dmem_lane_align #(
  parameter int DATA_WIDTH = 32,
  parameter int OFF        = 2
) (
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [OFF-1:0]        off,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rword,
  output logic [DATA_WIDTH-1:0] wdata_sh,
  output logic [DATA_WIDTH-1:0] rdata_ext
);
  import dmem_pkg::*;

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep;
  logic                  sign;

  // Shift store data to its lanes; right-align and extend load data.
  always_comb begin
    wdata_sh = wdata << {off, 3'b000};
    shifted  = rword >> {off, 3'b000};
    case (size)
      SZ_BYTE: begin keep = DATA_WIDTH'(8'hFF);         sign = shifted[7];  end
      SZ_HALF: begin keep = DATA_WIDTH'(16'hFFFF);      sign = shifted[15]; end
      SZ_WORD: begin keep = DATA_WIDTH'(32'hFFFF_FFFF); sign = shifted[31]; end
      default: begin keep = '1;                         sign = 1'b0;        end
    endcase
    sign      = sign & ~is_unsigned;
    rdata_ext = (shifted & keep) | (sign ? ~keep : '0);
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked byte-addressed data memory with sized, extending loads,
// alignment-fault detection and configurable response latency.
// Optional per-byte even parity: define DMEM_PARITY_EN.
module data_memory_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset_n,
`ifdef DMEM_PARITY_EN
  input  logic               inj_parity_err,
`endif
  data_memory_ctrl_if.slave  bus
);
  import dmem_pkg::*;

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam int CW    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  dmem_state_e           state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  fault_q;

  logic [IDXW-1:0]       idx;
  logic [OFF-1:0]        off;
  logic [2:0]            off3;
  logic [7:0]            be_full;
  logic [BYTES-1:0]      be;
  logic                  align_fault;
  logic                  accept;
  logic                  do_store;
  logic [DATA_WIDTH-1:0] rword;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rdata_ext;
  logic                  par_err;
  logic                  unused_bits;

  // Decode address, lanes and fault condition of the presented request.
  always_comb begin
    idx         = bus.req_addr[OFF+IDXW-1:OFF];
    off         = bus.req_addr[OFF-1:0];
    off3        = '0;
    off3[OFF-1:0] = off;
    be_full     = byte_enable(bus.req_size, off3);
    be          = be_full[BYTES-1:0];
    align_fault = access_fault(bus.req_size, off3, DATA_WIDTH == 64);
    accept      = bus.req_valid && (state == ST_IDLE);
    do_store    = accept && bus.req_write && !align_fault;
    rword       = mem[idx];
  end

  assign unused_bits = ^{bus.req_addr[ADDR_WIDTH-1:OFF+IDXW], be_full};

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFF        (OFF)
  ) u_align (
    .size        (bus.req_size),
    .is_unsigned (bus.req_unsigned),
    .off         (off),
    .wdata       (bus.req_wdata),
    .rword       (rword),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rdata_ext)
  );

  // Storage: cleared on reset, active lanes written on the accept edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned w = 0; w < DEPTH; w++) mem[w] <= '0;
    end else if (do_store) begin
      for (int unsigned b = 0; b < BYTES; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
  end

`ifdef DMEM_PARITY_EN
  logic [BYTES-1:0] par [DEPTH];
  logic [BYTES-1:0] rpar_calc;
  logic [BYTES-1:0] wpar_calc;

  // Recompute lane parity of the addressed word and of the new store data.
  always_comb begin
    for (int unsigned b = 0; b < BYTES; b++) begin
      rpar_calc[b] = ^rword[8*b +: 8];
      wpar_calc[b] = ^wdata_sh[8*b +: 8];
    end
    par_err = |(be & (par[idx] ^ rpar_calc));
  end

  // Parity storage tracks the data lanes; injection flips written lanes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned w = 0; w < DEPTH; w++) par[w] <= '0;
    end else if (do_store) begin
      for (int unsigned b = 0; b < BYTES; b++)
        if (be[b]) par[idx][b] <= wpar_calc[b] ^ inj_parity_err;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  // Controller: accept, optional latency wait, hold response until taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fault_q <= align_fault || (!bus.req_write && par_err);
            rdata_q <= (align_fault || bus.req_write) ? '0 : rdata_ext;
            cnt     <= CNT_INIT;
            state   <= (READ_LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        ST_RESP: begin
          if (bus.resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance at latency 1 and one at
// latency 3, each mirrored by a byte-level reference model.
module tb_data_memory_ctrl;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  vld = '0;
  logic [1:0]  rdy = '0;
  logic        t_write = 1'b0;
  logic [1:0]  t_size = '0;
  logic        t_uns = 1'b0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wdata = '0;

  logic        o_ready [2];
  logic        o_valid [2];
  logic [31:0] o_rdata [2];
  logic        o_fault [2];

  data_memory_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();
  data_memory_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifb ();

  assign ifa.req_valid = vld[0];      assign ifb.req_valid = vld[1];
  assign ifa.resp_ready = rdy[0];     assign ifb.resp_ready = rdy[1];
  assign ifa.req_write = t_write;     assign ifb.req_write = t_write;
  assign ifa.req_size = t_size;       assign ifb.req_size = t_size;
  assign ifa.req_unsigned = t_uns;    assign ifb.req_unsigned = t_uns;
  assign ifa.req_addr = t_addr;       assign ifb.req_addr = t_addr;
  assign ifa.req_wdata = t_wdata;     assign ifb.req_wdata = t_wdata;

  assign o_ready[0] = ifa.req_ready;  assign o_ready[1] = ifb.req_ready;
  assign o_valid[0] = ifa.resp_valid; assign o_valid[1] = ifb.resp_valid;
  assign o_rdata[0] = ifa.resp_rdata; assign o_rdata[1] = ifb.resp_rdata;
  assign o_fault[0] = ifa.resp_fault; assign o_fault[1] = ifb.resp_fault;

  data_memory_ctrl #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .READ_LATENCY(LAT0)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ifa.slave)
  );

  data_memory_ctrl #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .READ_LATENCY(LAT1)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 64 bytes per instance, busy/age bookkeeping per instance.
  logic [7:0]  mm [2][64];
  logic        m_busy [2];
  logic        m_valid [2];
  int          m_age [2];
  logic [31:0] m_rdata [2];
  logic        m_fault [2];

  function automatic int lat(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  task automatic model_access(input int i);
    int n;
    int a;
    logic [63:0] v;
    n = 1 << t_size;
    a = int'(t_addr[5:0]);
    m_rdata[i] = '0;
    m_fault[i] = (t_size == 2'b11) || (a % n != 0);
    if (m_fault[i]) return;
    if (t_write) begin
      for (int k = 0; k < n; k++) mm[i][a+k] = t_wdata[8*k +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v = v | (64'(mm[i][a+k]) << (8*k));
      if (!t_uns && v[8*n-1]) v = v | ~((64'h1 << (8*n)) - 64'h1);
      m_rdata[i] = v[31:0];
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int b = 0; b < 64; b++) mm[i][b] = 8'h00;
        m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_age[i] = 0;
        m_rdata[i] = '0;  m_fault[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (vld[i]) begin
            model_access(i);
            m_busy[i] = 1'b1;
            m_age[i] = 1;
            m_valid[i] = (m_age[i] >= lat(i));
          end
        end else if (m_valid[i]) begin
          if (rdy[i]) begin
            m_busy[i] = 1'b0;
            m_valid[i] = 1'b0;
          end
        end else begin
          m_age[i]++;
          m_valid[i] = (m_age[i] >= lat(i));
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("req_ready[%0d]", i), 64'(o_ready[i]), 64'(!m_busy[i]));
        chk($sformatf("resp_valid[%0d]", i), 64'(o_valid[i]), 64'(m_valid[i]));
        if (m_valid[i]) begin
          chk($sformatf("resp_rdata[%0d]", i), 64'(o_rdata[i]), 64'(m_rdata[i]));
          chk($sformatf("resp_fault[%0d]", i), 64'(o_fault[i]), 64'(m_fault[i]));
        end
      end
    end
  end

  // One request/response; hold delays resp_ready, keep_v holds req_valid.
  task automatic txn(input int sel, input logic w, input logic [1:0] sz,
                     input logic u, input logic [31:0] a, input logic [31:0] wd,
                     input int hold, input logic keep_v,
                     output logic [31:0] rd, output logic f);
    int n;
    @(negedge clock);
    t_write = w; t_size = sz; t_uns = u; t_addr = a; t_wdata = wd;
    vld[sel] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    if (!keep_v) vld[sel] = 1'b0;
    n = 0;
    while (!o_valid[sel] && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!o_valid[sel]) begin
      chk("resp_timeout", 64'(0), 64'(1));
      vld[sel] = 1'b0;
      rd = 'x; f = 1'bx;
      return;
    end
    rd = o_rdata[sel];
    f  = o_fault[sel];
    for (int h = 0; h < hold; h++) begin
      chk("hold_req_ready", 64'(o_ready[sel]), 64'(0));
      chk("hold_rdata", 64'(o_rdata[sel]), 64'(rd));
      @(negedge clock);
    end
    rdy[sel] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rdy[sel] = 1'b0;
    vld[sel] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        f;

  initial begin
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 64'(o_ready[i]), 64'(1));
      chk("rst_resp_valid", 64'(o_valid[i]), 64'(0));
      chk("rst_resp_rdata", 64'(o_rdata[i]), 64'(0));
      chk("rst_resp_fault", 64'(o_fault[i]), 64'(0));
    end

    // Latency-1 instance.
    txn(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0, rd, f);
    chk("ld_w_0", 64'(rd), 64'h0);  chk("ld_w_0_f", 64'(f), 64'(0));
    txn(0, 1, 2'b10, 0, 32'h8, 32'h8899AABB, 0, 0, rd, f);
    chk("st_w_8_f", 64'(f), 64'(0));
    txn(0, 1, 2'b00, 0, 32'h9, 32'hFFFFFF11, 0, 0, rd, f);
    txn(0, 0, 2'b10, 0, 32'h8, 32'h0, 0, 0, rd, f);
    chk("ld_w_8", 64'(rd), 64'h889911BB);
    txn(0, 0, 2'b00, 0, 32'h8, 32'h0, 0, 0, rd, f);
    chk("ld_b_8_s", 64'(rd), 64'hFFFFFFBB);
    txn(0, 0, 2'b00, 1, 32'h8, 32'h0, 0, 0, rd, f);
    chk("ld_b_8_u", 64'(rd), 64'h000000BB);
    txn(0, 0, 2'b01, 0, 32'hA, 32'h0, 0, 0, rd, f);
    chk("ld_h_A_s", 64'(rd), 64'hFFFF8899);
    txn(0, 1, 2'b10, 0, 32'h6, 32'hDEADBEEF, 0, 0, rd, f);
    chk("st_w_6_f", 64'(f), 64'(1));  chk("st_w_6_rd", 64'(rd), 64'h0);
    txn(0, 0, 2'b10, 0, 32'h4, 32'h0, 0, 0, rd, f);
    chk("ld_w_4_unchanged", 64'(rd), 64'h0);
    txn(0, 0, 2'b01, 0, 32'h3, 32'h0, 0, 0, rd, f);
    chk("ld_h_3_f", 64'(f), 64'(1));  chk("ld_h_3_rd", 64'(rd), 64'h0);
    txn(0, 0, 2'b11, 0, 32'h0, 32'h0, 0, 0, rd, f);
    chk("ld_d_f", 64'(f), 64'(1));
    txn(0, 1, 2'b10, 0, 32'h40, 32'h12345678, 0, 0, rd, f);
    txn(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0, rd, f);
    chk("ld_w_wrap", 64'(rd), 64'h12345678);
    txn(0, 1, 2'b01, 0, 32'h12, 32'h0000BEEF, 0, 0, rd, f);
    txn(0, 0, 2'b01, 1, 32'h12, 32'h0, 0, 0, rd, f);
    chk("ld_h_12_u", 64'(rd), 64'h0000BEEF);
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 0, rd, f);
    chk("ld_w_10", 64'(rd), 64'hBEEF0000);

    // Latency-3 instance: held response with req_valid kept high.
    txn(1, 1, 2'b10, 0, 32'h4, 32'hCAFEF00D, 0, 0, rd, f);
    txn(1, 0, 2'b10, 0, 32'h4, 32'h0, 4, 1, rd, f);
    chk("l3_ld_w_4", 64'(rd), 64'hCAFEF00D);

    // Reset pulsed while the latency-3 load is waiting.
    @(negedge clock);
    t_write = 0; t_size = 2'b10; t_uns = 0; t_addr = 32'h4;
    vld[1] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vld[1] = 1'b0;
    chk("l3_wait_ready", 64'(o_ready[1]), 64'(0));
    #2 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("abort_valid", 64'(o_valid[1]), 64'(0));
      chk("abort_ready", 64'(o_ready[1]), 64'(1));
    end
    txn(1, 0, 2'b10, 0, 32'h4, 32'h0, 0, 0, rd, f);
    chk("l3_after_rst", 64'(rd), 64'h0);
    txn(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0, rd, f);
    chk("l1_after_rst", 64'(rd), 64'h0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
